// File: rtl/inst_prefetch_buf.sv
// rtl/inst_prefetch_buf.sv - sequential instruction prefetch FIFO with replay and flush-on-branch
module inst_prefetch_buf #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_inst_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + MEM_LAT + 1) + 1;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  // infl_v[0] is the youngest request, infl_v[MEM_LAT-1] returns data this cycle
  logic [MEM_LAT-1:0] infl_v;
  logic [ADDR_W-1:0]  infl_addr [MEM_LAT];

  logic [ADDR_W-1:0] fetch_addr, last_addr;
  logic [DATA_W-1:0] last_data;
  logic              last_v;

  logic              active, replay, hit, pending, pop, push, flush, req;
  logic              old_v;
  logic [ADDR_W-1:0] old_addr, req_addr;
  logic [CW-1:0]     infl_cnt, used;

  always_comb begin
    infl_cnt = '0;
    old_v    = 1'b0;
    old_addr = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      infl_cnt = infl_cnt + CW'(infl_v[i]);
      if (infl_v[i]) begin
        old_v    = 1'b1;
        old_addr = infl_addr[i];
      end
    end
  end

  always_comb begin
    active   = rst && cpu_ce_i;
    replay   = last_v && (cpu_addr_i == last_addr);
    hit      = !replay && (count != '0) && (fifo_addr[rd_ptr] == cpu_addr_i);
    pending  = !replay && (count == '0) && old_v && (old_addr == cpu_addr_i);
    pop      = active && hit;
    flush    = active && !replay && !hit && !pending;
    push     = active && !flush && infl_v[MEM_LAT-1];
    used     = count + infl_cnt - CW'(pop);
    req      = active && (flush || (used < CW'(DEPTH)));
    req_addr = flush ? cpu_addr_i : fetch_addr;
  end

  assign mem_req_o   = req;
  assign mem_addr_o  = req ? req_addr : '0;
  assign cpu_stall_o = active && !replay && !hit;
  assign cpu_inst_o  = !active ? '0 :
                       replay  ? last_data :
                       hit     ? fifo_data[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      infl_v     <= '0;
      last_v     <= 1'b0;
      fetch_addr <= '0;
    end else if (!cpu_ce_i) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      infl_v <= '0;
      last_v <= 1'b0;
    end else if (flush) begin
      // The response landing this cycle belongs to the abandoned stream and is dropped
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      infl_v     <= MEM_LAT'(1);
      last_v     <= 1'b0;
      fetch_addr <= cpu_addr_i + ADDR_W'(4);
    end else begin
      assert (!(push && !pop && count == CW'(DEPTH)));
      infl_v <= (infl_v << 1) | MEM_LAT'(req);
      if (req) fetch_addr <= fetch_addr + ADDR_W'(4);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        last_v    <= 1'b1;
        last_addr <= fifo_addr[rd_ptr];
        last_data <= fifo_data[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    infl_addr[0] <= req_addr;
    for (int i = MEM_LAT - 1; i > 0; i--) infl_addr[i] <= infl_addr[i-1];
    if (push) begin
      fifo_addr[wr_ptr] <= infl_addr[MEM_LAT-1];
      fifo_data[wr_ptr] <= mem_data_i;
    end
  end
endmodule

// File: tb/tb_inst_prefetch_buf.sv
// tb/tb_inst_prefetch_buf.sv - directed bench with queue-based reference model for inst_prefetch_buf
module tb_inst_prefetch_buf;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam logic [31:0] K = 32'hA5A50000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] inst, maddr, mdata;
  logic        stall, mreq;

  always #5 clk = ~clk;

  inst_prefetch_buf #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cpu_ce_i(ce), .cpu_addr_i(addr),
    .cpu_inst_o(inst), .cpu_stall_o(stall),
    .mem_req_o(mreq), .mem_addr_o(maddr), .mem_data_i(mdata)
  );

  // Memory: data = addr ^ K exactly LAT cycles after the request
  logic [LAT-1:0] mp_v = '0;
  logic [31:0]    mp_a [LAT];
  always @(posedge clk) begin
    mp_v    <= {mp_v[LAT-2:0], mreq};
    mp_a[0] <= maddr;
    for (int i = 1; i < LAT; i++) mp_a[i] <= mp_a[i-1];
  end
  assign mdata = mp_v[LAT-1] ? (mp_a[LAT-1] ^ K) : 32'hDEADBEEF;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    int          due;
  } ent_t;

  logic [31:0] fq [$];
  ent_t        iq [$];
  logic [31:0] m_fetch = '0;
  logic [31:0] m_last = '0;
  logic        m_last_v = 1'b0;
  int          cyc = 0;

  always @(negedge clk) begin : model
    logic [31:0] e_inst, e_addr;
    logic        e_stall, e_req, rep, hit, pend;
    int          used;
    ent_t        e;
    #2;
    e_inst = '0; e_addr = '0; e_stall = 1'b0; e_req = 1'b0;
    if (!rst) begin
      fq.delete(); iq.delete(); m_last_v = 1'b0; m_fetch = '0;
    end else if (!ce) begin
      fq.delete(); iq.delete(); m_last_v = 1'b0;
    end else begin
      rep  = m_last_v && addr == m_last;
      hit  = !rep && fq.size() > 0 && fq[0] == addr;
      pend = !rep && !hit && fq.size() == 0 && iq.size() > 0 && iq[0].a == addr;
      e_stall = !(rep || hit);
      if (rep || hit) e_inst = addr ^ K;
      if (!rep && !hit && !pend) begin
        e_req = 1'b1; e_addr = addr;
        fq.delete(); iq.delete(); m_last_v = 1'b0;
        e.a = addr; e.due = cyc + LAT; iq.push_back(e);
        m_fetch = addr + 32'd4;
      end else begin
        used  = fq.size() + iq.size() - (hit ? 1 : 0);
        e_req = used < DEPTH;
        if (e_req) e_addr = m_fetch;
        if (hit) begin
          void'(fq.pop_front());
          m_last_v = 1'b1; m_last = addr;
        end
        if (iq.size() > 0 && iq[0].due == cyc) begin
          fq.push_back(iq[0].a);
          void'(iq.pop_front());
        end
        if (e_req) begin
          e.a = m_fetch; e.due = cyc + LAT; iq.push_back(e);
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    chk("m_inst", inst, e_inst);
    chk("m_stall", {31'd0, stall}, {31'd0, e_stall});
    chk("m_req", {31'd0, mreq}, {31'd0, e_req});
    chk("m_addr", maddr, e_addr);
    cyc++;
  end

  task automatic tick(input logic r, input logic c, input logic [31:0] a);
    @(negedge clk);
    rst = r; ce = c; addr = a;
    #3;
  endtask

  task automatic deliver(input logic [31:0] a, output int ns);
    ns = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1, a);
      if (!stall) break;
      ns++;
    end
  endtask

  initial begin
    logic [31:0] pc;
    int ns;

    repeat (3) begin
      tick(1'b0, 1'b1, 32'h40);
      chk("reset_req", {31'd0, mreq}, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
      chk("reset_inst", inst, 32'd0);
    end

    pc = 32'h0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b1, pc);
      if (k < 4) begin
        chk("cold_req", {31'd0, mreq}, 32'd1);
        chk("cold_addr", maddr, 32'(k * 4));
      end
      if (k < 3) chk("cold_stall", {31'd0, stall}, 32'd1);
      else chk("cold_inst", inst, 32'((k - 3) * 4) ^ K);
      if (!stall) pc = pc + 32'd4;
    end

    deliver(32'h100, ns);
    chk("branch_stalls", 32'(ns), 32'd3);
    chk("branch_inst", inst, 32'hA5A50100);

    deliver(32'h0, ns);
    chk("rp_miss_stalls", 32'(ns), 32'd3);
    deliver(32'h4, ns);
    deliver(32'h8, ns);
    chk("rp_hit_stalls", 32'(ns), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 32'h8);
      chk("replay_inst", inst, 32'hA5A50008);
      chk("replay_stall", {31'd0, stall}, 32'd0);
      if (i > 0) chk("replay_req_off", {31'd0, mreq}, 32'd0);
    end
    deliver(32'hC, ns);
    chk("after_replay_stalls", 32'(ns), 32'd0);
    chk("after_replay_inst", inst, 32'hA5A5000C);
    deliver(32'h10, ns);
    deliver(32'h14, ns);

    repeat (2) begin
      tick(1'b1, 1'b0, 32'h18);
      chk("dis_inst", inst, 32'd0);
      chk("dis_stall", {31'd0, stall}, 32'd0);
      chk("dis_req", {31'd0, mreq}, 32'd0);
    end
    deliver(32'h20, ns);
    chk("reen_stalls", 32'(ns), 32'd3);
    chk("reen_inst", inst, 32'hA5A50020);

    repeat (6) tick(1'b1, 1'b1, 32'h20);
    tick(1'b0, 1'b1, 32'h24);
    chk("midrst_req", {31'd0, mreq}, 32'd0);
    chk("midrst_inst", inst, 32'd0);
    tick(1'b1, 1'b1, 32'h24);
    chk("postrst_stall", {31'd0, stall}, 32'd1);
    chk("postrst_addr", maddr, 32'h24);
    deliver(32'h24, ns);
    chk("postrst_stalls", 32'(ns), 32'd2);
    chk("postrst_inst", inst, 32'hA5A50024);

    deliver(32'hFFFFFFF8, ns);
    chk("wrap_miss_stalls", 32'(ns), 32'd3);
    deliver(32'hFFFFFFFC, ns);
    chk("wrap_fc_stalls", 32'(ns), 32'd0);
    chk("wrap_fc_inst", inst, 32'h5A5AFFFC);
    deliver(32'h0, ns);
    chk("wrap_0_stalls", 32'(ns), 32'd0);
    chk("wrap_0_inst", inst, 32'hA5A50000);
    deliver(32'h4, ns);
    chk("wrap_4_inst", inst, 32'hA5A50004);

    repeat (2) tick(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
